// File: rtl/fifo_wr_pkg.sv
// Shared types and constants for the FIFO write-side controller.
// Build option: FIFO_WR_PRBS_EN selects the PRBS data pattern.
package fifo_wr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    FILL   = 2'd2,
    DONE   = 2'd3
  } wr_state_e;

  // Taps for x^8+x^6+x^5+x^4+1, bit n-1 holds the x^n term
  localparam logic [7:0] PRBS8_TAPS = 8'hB8;
  localparam logic [7:0] PRBS_SEED  = 8'h01;
  localparam logic [7:0] CNT_SEED   = 8'h00;

  function automatic logic prbs8_fb(input logic [7:0] s);
    return ^(s & PRBS8_TAPS);
  endfunction

endpackage

// File: rtl/fifo_wr_pattern_gen.sv
// Write-data pattern source; advances one step per accepted write.
// FIFO_WR_PRBS_EN defined: 8-bit Fibonacci LFSR (DATA_W=8), else wrapping counter.
module fifo_wr_pattern_gen
  import fifo_wr_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;

`ifdef FIFO_WR_PRBS_EN
  localparam logic [DATA_W-1:0] SEED = DATA_W'(PRBS_SEED);

  always_comb begin
    data_d = {data_q[DATA_W-2:0], prbs8_fb(data_q[7:0])};
  end
`else
  localparam logic [DATA_W-1:0] SEED = DATA_W'(CNT_SEED);

  always_comb begin
    data_d = data_q + {{(DATA_W-1){1'b0}}, 1'b1};
  end
`endif

  // Not cleared between bursts: the sequence carries on across bursts
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= SEED;
    end else if (adv) begin
      data_q <= data_d;
    end
  end

  assign data = data_q;

endmodule

// File: rtl/fifo_wr_ctrl.sv
// FIFO write-side controller: wait for empty, settle, then burst-write a pattern.
// Build option: FIFO_WR_PRBS_EN (PRBS pattern instead of incrementing counter).
module fifo_wr_ctrl
  import fifo_wr_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned SETTLE_CYC = 10,
  parameter int unsigned BURST_MAX  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              wr_empty,
  input  logic              wr_full,
  output logic              wr_req,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              burst_done,
  output logic [15:0]       burst_cnt
);

  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [15:0] BURST_LIM   = 16'(BURST_MAX);

  wr_state_e   state_q, state_d;
  logic [7:0]  settle_q, settle_d;
  logic [15:0] word_q, word_d;
  logic [15:0] bcnt_q, bcnt_d;
  logic        req;

  // Gated by the live full flag so a late full never causes an overwrite
  assign req = (state_q == FILL) && !wr_full && (word_q < BURST_LIM) && en;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    word_d   = word_q;
    bcnt_d   = bcnt_q;

    if (req) begin
      word_d = word_q + 16'd1;
    end

    case (state_q)
      IDLE: begin
        if (en && wr_empty) begin
          state_d  = SETTLE;
          settle_d = '0;
          word_d   = '0;
        end
      end
      SETTLE: begin
        if (!en) begin
          state_d = DONE;
        end else if (settle_q == SETTLE_LAST) begin
          state_d = FILL;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      FILL: begin
        if (!en || wr_full || (word_d == BURST_LIM)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Latched on entry so the count is valid alongside the done pulse
    if ((state_d == DONE) && (state_q != DONE)) begin
      bcnt_d = word_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      settle_q <= '0;
      word_q   <= '0;
      bcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      word_q   <= word_d;
      bcnt_q   <= bcnt_d;
    end
  end

  fifo_wr_pattern_gen #(
    .DATA_W (DATA_W)
  ) u_pattern (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (req),
    .data  (wr_data)
  );

  assign wr_req     = req;
  assign busy       = (state_q == SETTLE) || (state_q == FILL);
  assign burst_done = (state_q == DONE);
  assign burst_cnt  = bcnt_q;

endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
Write-side controller for the IP FIFO demo; drives the FIFO write port upstream of the read-side controller. Waits for the FIFO to report empty, lets the flags settle, then burst-writes a generated data pattern until the FIFO reports full or a burst limit is reached. Exposes busy, done and count status for LEDs and debug.

Parameters:
DATA_W, 8, width of wr_data and pattern generator
SETTLE_CYC, 10, cycles to wait after empty is seen before writing (covers dcfifo flag latency); legal 1..255
BURST_MAX, 256, maximum words per burst; legal 1..65535

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; reset is synchronous and active-low
en  in  1  enable; 0 holds controller in IDLE after current cycle
wr_empty  in  1  FIFO write-side empty flag
wr_full  in  1  FIFO write-side full flag
wr_req  out  1  FIFO write request, one word per cycle high
wr_data  out  DATA_W  FIFO write data, valid with wr_req
busy  out  1  high in SETTLE and FILL
burst_done  out  1  one-cycle pulse when a burst ends
burst_cnt  out  16  words written in last completed burst

Behaviour:
- Reset (rst_n low at clk edge): state IDLE; wr_req 0, wr_data seed, busy 0, burst_done 0, burst_cnt 0, settle and word counters 0.
- States: IDLE -> SETTLE when en & wr_empty; SETTLE counts SETTLE_CYC cycles, then -> FILL; FILL -> DONE when write terminates; DONE (one cycle, burst_done=1, burst_cnt latched) -> IDLE.
- en low in SETTLE or FILL: -> DONE next edge; partial count reported.
- wr_req = (state==FILL) & ~wr_full & (word_cnt < BURST_MAX) & en; combinational gate so a late full flag never causes an overwrite.
- Accepted write = wr_req high at clk edge; word_cnt increments, pattern advances next cycle; wr_data stable while wr_req low.
- FILL terminates when wr_full high or word_cnt reaches BURST_MAX; the last accepted word is counted.
- wr_full already high on entry to FILL: zero words, DONE with burst_cnt 0.
- wr_empty and wr_full both high: full wins (no write).
- wr_empty ignored outside IDLE; deasserting it in SETTLE does not abort.
- Pattern is not reset between bursts; continues from last value.
- word_cnt 16-bit, saturates at BURST_MAX; burst_cnt updated only in DONE.
- Latency: empty seen in IDLE -> first wr_req exactly SETTLE_CYC+1 cycles later.

Optional Feature:
FIFO_WR_PRBS_EN: defined -> pattern is PRBS (Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1 for DATA_W=8), seed 8'h01, never all-zero. Undefined -> incrementing counter, seed 0, wraps modulo 2^DATA_W (8'hFF -> 8'h00).

Decomposition:
- Package fifo_wr_pkg: state enum (IDLE, SETTLE, FILL, DONE), PRBS tap constant, seed constants.
- Sub-module fifo_wr_pattern_gen: inputs clk, rst_n, adv; output data; holds counter/LFSR and the macro selection.
- Top holds FSM, settle/word counters, status registers.

Test Plan:
- Reset, en=1, wr_empty=1, wr_full=0, SETTLE_CYC=10 -> first wr_req at cycle 11, wr_data 0,1,2... each cycle (counter mode).
- wr_full asserted after 256 words, BURST_MAX=512 -> wr_req drops same cycle full rises; burst_done pulse; burst_cnt=256.
- BURST_MAX=16, never full -> exactly 16 writes, data 0..15; next burst after re-empty starts at 16.
- en dropped after 5 writes -> wr_req low next cycle, burst_cnt=5, state IDLE.
- wr_full high on FILL entry -> no writes, burst_cnt=0; wr_empty=wr_full=1 in FILL -> no write.
- FIFO_WR_PRBS_EN defined -> first words 01, then LFSR sequence matching model; 255 words without repeat, never 00; rst_n low mid-FILL -> all outputs to reset values next edge.
